// File: rtl/uart_loader_ctrl_pkg.sv
// Shared types and constants for the UART boot loader.
// Optional feature macro: LOADER_CHECKSUM_EN adds the CHECK state.
package loader_pkg;

    localparam int LOADER_LEN_WID     = 16;
    localparam int LOADER_BYTE_WID    = 8;
    localparam int LOADER_TIMEOUT_CYC = 5_000_000;

    typedef enum logic [2:0] {
        LEN_HI,
        LEN_LO,
        DATA,
`ifdef LOADER_CHECKSUM_EN
        CHECK,
`endif
        DONE
    } loader_state_t;

endpackage

// File: rtl/uart_loader_ctrl_if.sv
// Byte-stream input and memory-write output bundle of the loader.
// The slave side is the loader itself; the master side feeds bytes and
// observes the memory writes.
interface uart_loader_ctrl_if;
    import loader_pkg::*;

    logic [LOADER_BYTE_WID-1:0] rx_data;
    logic                       rx_valid;
    logic                       mem_we;
    logic [31:0]                mem_addr;
    logic [31:0]                mem_data;
    logic                       done;
    logic                       err;
    logic [LOADER_LEN_WID-1:0]  words_loaded;

    modport master (
        output rx_data, rx_valid,
        input  mem_we, mem_addr, mem_data, done, err, words_loaded
    );

    modport slave (
        input  rx_data, rx_valid,
        output mem_we, mem_addr, mem_data, done, err, words_loaded
    );

endinterface

// File: rtl/uart_loader_ctrl_timeout.sv
// Inter-byte gap counter. expired is high during the TIMEOUT_CYC-th
// consecutive enabled cycle without a restart.
module loader_timeout
    import loader_pkg::*;
#(
    parameter int TIMEOUT_CYC = LOADER_TIMEOUT_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    input  logic enable,
    output logic expired
);

    localparam int              CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] r_count;

    // Count idle cycles while a frame is open; any accepted byte or an idle state clears it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (restart || !enable) begin
            r_count <= '0;
        end else if (r_count != LIMIT) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign expired = enable && (r_count == LIMIT);

endmodule

// File: rtl/uart_loader_ctrl.sv
// UART image loader: parses a length-prefixed frame of little-endian words
// and writes them to memory starting at BASE_ADDR, then raises sticky done.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module uart_loader_ctrl
    import loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          TIMEOUT_CYC = LOADER_TIMEOUT_CYC
) (
    input  logic              clk,
    input  logic              rst,
    uart_loader_ctrl_if.slave bus
);

    loader_state_t             r_state;
    logic [LOADER_LEN_WID-1:0] r_len;
    logic [LOADER_LEN_WID-1:0] r_wordsLoaded;
    logic [23:0]               r_asm;
    logic [1:0]                r_byteCnt;
    logic                      r_memWe;
    logic [31:0]               r_memAddr;
    logic [31:0]               r_memData;
    logic                      r_done;
    logic                      r_err;

    logic                      w_expired;
    logic                      w_timerEn;
    logic                      w_accept;
    logic                      w_abort;
    logic [LOADER_LEN_WID-1:0] w_lenFull;
    logic [LOADER_LEN_WID-1:0] w_nextWords;
    logic [31:0]               w_wordAddr;

`ifdef LOADER_CHECKSUM_EN
    logic [LOADER_BYTE_WID-1:0] r_csum;
    logic                       w_csumBad;

    assign w_csumBad = (r_state == CHECK) && bus.rx_valid && (bus.rx_data != r_csum);
`endif

    assign w_timerEn   = (r_state != LEN_HI) && (r_state != DONE);
    assign w_accept    = bus.rx_valid && (r_state != DONE);
    assign w_lenFull   = {r_len[15:8], bus.rx_data};
    assign w_nextWords = r_wordsLoaded + 16'd1;
    assign w_wordAddr  = BASE_ADDR + {14'd0, r_wordsLoaded, 2'b00};

    // A byte arriving in the expiry cycle wins over the timeout
`ifdef LOADER_CHECKSUM_EN
    assign w_abort = (w_expired && !bus.rx_valid) || w_csumBad;
`else
    assign w_abort = w_expired && !bus.rx_valid;
`endif

    loader_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .restart (w_accept),
        .enable  (w_timerEn),
        .expired (w_expired)
    );

    // Frame parser, byte assembler and registered memory-write outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= LEN_HI;
            r_len         <= '0;
            r_wordsLoaded <= '0;
            r_asm         <= '0;
            r_byteCnt     <= '0;
            r_memWe       <= 1'b0;
            r_memAddr     <= BASE_ADDR;
            r_memData     <= '0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            r_csum        <= '0;
`endif
        end else begin
            r_memWe <= 1'b0;
            r_err   <= 1'b0;
            if (w_abort) begin
                r_state       <= LEN_HI;
                r_err         <= 1'b1;
                r_asm         <= '0;
                r_byteCnt     <= '0;
                r_wordsLoaded <= '0;
`ifdef LOADER_CHECKSUM_EN
                r_csum        <= '0;
`endif
            end else begin
                case (r_state)
                    LEN_HI: begin
                        if (bus.rx_valid) begin
                            r_len[15:8] <= bus.rx_data;
                            r_state     <= LEN_LO;
                        end
                    end
                    LEN_LO: begin
                        if (bus.rx_valid) begin
                            r_len <= w_lenFull;
                            if (w_lenFull == '0) begin
`ifdef LOADER_CHECKSUM_EN
                                r_state <= CHECK;
`else
                                r_state <= DONE;
`endif
                            end else begin
                                r_state <= DATA;
                            end
                        end
                    end
                    DATA: begin
                        if (bus.rx_valid) begin
                            r_byteCnt <= r_byteCnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                            r_csum    <= r_csum ^ bus.rx_data;
`endif
                            if (r_byteCnt == 2'd3) begin
                                r_memWe       <= 1'b1;
                                r_memAddr     <= w_wordAddr;
                                r_memData     <= {bus.rx_data, r_asm};
                                r_wordsLoaded <= w_nextWords;
                                r_asm         <= '0;
                                if (w_nextWords == r_len) begin
`ifdef LOADER_CHECKSUM_EN
                                    r_state <= CHECK;
`else
                                    r_state <= DONE;
`endif
                                end
                            end else begin
                                r_asm <= {bus.rx_data, r_asm[23:8]};
                            end
                        end
                    end
`ifdef LOADER_CHECKSUM_EN
                    CHECK: begin
                        if (bus.rx_valid) begin
                            r_state <= DONE;
                        end
                    end
`endif
                    DONE: begin
                        r_done <= 1'b1;
                    end
                    default: begin
                        r_state <= LEN_HI;
                    end
                endcase
            end
        end
    end

    assign bus.mem_we       = r_memWe;
    assign bus.mem_addr     = r_memAddr;
    assign bus.mem_data     = r_memData;
    assign bus.done         = r_done;
    assign bus.err          = r_err;
    assign bus.words_loaded = r_wordsLoaded;

endmodule

// File: tb/tb_uart_loader_ctrl.sv
// Directed bench for uart_loader_ctrl (TIMEOUT_CYC=16, BASE_ADDR=0).
// Works with and without LOADER_CHECKSUM_EN.
module tb_uart_loader_ctrl;
    import loader_pkg::*;

    typedef logic [7:0] byteQ_t [$];

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_loader_ctrl_if bus ();

    uart_loader_ctrl #(
        .BASE_ADDR   (32'h0000_0000),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          assertCount = 0;
    int          failCount   = 0;
    int          errCount    = 0;
    logic [31:0] wrAddr [$];
    logic [31:0] wrData [$];

    // Record every write and every err-high cycle, sampled mid-cycle
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            wrAddr.push_back(bus.mem_addr);
            wrData.push_back(bus.mem_data);
        end
        if (bus.err === 1'b1) errCount++;
    end

    // Hard stop if anything hangs
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkWrite(input int k, input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] a = 'x;
        logic [31:0] d = 'x;
        if (k < wrAddr.size()) begin
            a = wrAddr[k];
            d = wrData[k];
        end
        checkOutput($sformatf("write%0d_addr", k), a, addr);
        checkOutput($sformatf("write%0d_data", k), d, data);
    endtask

    task automatic clearCapture();
        wrAddr.delete();
        wrData.delete();
        errCount = 0;
    endtask

    // Called at a negedge; presents one byte for one cycle then idles
    task automatic applyStimulus(input logic [7:0] b, input int idle);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        repeat (idle) @(negedge clk);
    endtask

    task automatic applyFrame(input logic [15:0] n, input byteQ_t data, input int idle);
        byteQ_t all;
`ifdef LOADER_CHECKSUM_EN
        logic [7:0] x = 8'h00;
        foreach (data[i]) x ^= data[i];
`endif
        all.push_back(n[15:8]);
        all.push_back(n[7:0]);
        foreach (data[i]) all.push_back(data[i]);
`ifdef LOADER_CHECKSUM_EN
        all.push_back(x);
`endif
        for (int i = 0; i < all.size(); i++)
            applyStimulus(all[i], (i == all.size() - 1) ? 0 : idle);
    endtask

    task automatic applyReset();
        rst          = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clearCapture();
    endtask

    initial begin
        byteQ_t d;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;

        // Reset values
        repeat (3) @(negedge clk);
        checkOutput("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
        checkOutput("rst_mem_addr", bus.mem_addr, 32'h0);
        checkOutput("rst_mem_data", bus.mem_data, 32'h0);
        checkOutput("rst_done", {31'd0, bus.done}, 32'd0);
        checkOutput("rst_err", {31'd0, bus.err}, 32'd0);
        checkOutput("rst_words", {16'd0, bus.words_loaded}, 32'd0);
        rst = 1'b0;
        clearCapture();

        // Two-word frame, done timing
        d = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        applyFrame(16'd2, d, 1);
`ifndef LOADER_CHECKSUM_EN
        checkOutput("two_we_last", {31'd0, bus.mem_we}, 32'd1);
`endif
        checkOutput("two_done_entry", {31'd0, bus.done}, 32'd0);
        @(negedge clk);
        checkOutput("two_done_next", {31'd0, bus.done}, 32'd1);
        repeat (3) @(negedge clk);
        checkOutput("two_nwrites", wrAddr.size(), 32'd2);
        checkWrite(0, 32'h0, 32'h1234_5678);
        checkWrite(1, 32'h4, 32'hDEAD_BEEF);
        checkOutput("two_words", {16'd0, bus.words_loaded}, 32'd2);
        checkOutput("two_done_hold", {31'd0, bus.done}, 32'd1);

        // Empty frame then ignored trailing bytes
        applyReset();
        d = {};
        applyFrame(16'd0, d, 0);
        for (int i = 0; i < 6; i++) applyStimulus(8'h11 * i[7:0], 0);
        repeat (3) @(negedge clk);
        checkOutput("empty_nwrites", wrAddr.size(), 32'd0);
        checkOutput("empty_done", {31'd0, bus.done}, 32'd1);
        checkOutput("empty_words", {16'd0, bus.words_loaded}, 32'd0);

        // Long gap after second data byte aborts the frame
        applyReset();
        applyStimulus(8'h00, 0);
        applyStimulus(8'h01, 0);
        applyStimulus(8'h11, 0);
        applyStimulus(8'h22, 20);
        checkOutput("gap_err_pulses", errCount, 32'd1);
        checkOutput("gap_words", {16'd0, bus.words_loaded}, 32'd0);
        checkOutput("gap_done", {31'd0, bus.done}, 32'd0);
        d = '{8'h11, 8'h22, 8'h33, 8'h44};
        applyFrame(16'd1, d, 0);
        repeat (3) @(negedge clk);
        checkOutput("gap_nwrites", wrAddr.size(), 32'd1);
        checkWrite(0, 32'h0, 32'h4433_2211);
        checkOutput("gap_reload_done", {31'd0, bus.done}, 32'd1);
        checkOutput("gap_err_total", errCount, 32'd1);

        // Bytes landing exactly on the expiry cycle are accepted
        applyReset();
        d = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        applyFrame(16'd1, d, 15);
        repeat (3) @(negedge clk);
        checkOutput("edge_err", errCount, 32'd0);
        checkWrite(0, 32'h0, 32'hD4C3_B2A1);
        checkOutput("edge_done", {31'd0, bus.done}, 32'd1);

        // One cycle longer gap is a timeout
        applyReset();
        applyStimulus(8'h00, 0);
        applyStimulus(8'h01, 0);
        applyStimulus(8'h55, 16);
        applyStimulus(8'h66, 2);
        checkOutput("edge16_err", errCount, 32'd1);

`ifdef LOADER_CHECKSUM_EN
        // Good and bad checksum
        applyReset();
        d = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
        foreach (d[i]) applyStimulus(d[i], 0);
        repeat (2) @(negedge clk);
        checkOutput("csum_ok_done", {31'd0, bus.done}, 32'd1);
        checkOutput("csum_ok_err", errCount, 32'd0);
        applyReset();
        d = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        foreach (d[i]) applyStimulus(d[i], 0);
        repeat (3) @(negedge clk);
        checkOutput("csum_bad_err", errCount, 32'd1);
        checkOutput("csum_bad_done", {31'd0, bus.done}, 32'd0);
        checkOutput("csum_bad_words", {16'd0, bus.words_loaded}, 32'd0);
        d = '{8'h09, 8'h08, 8'h07, 8'h06};
        applyFrame(16'd1, d, 0);
        repeat (2) @(negedge clk);
        checkOutput("csum_restart_done", {31'd0, bus.done}, 32'd1);
`endif

        // Reset in the middle of the second word
        applyReset();
        applyStimulus(8'h00, 1);
        applyStimulus(8'h02, 1);
        for (int i = 1; i <= 5; i++) applyStimulus(i[7:0], 1);
        checkOutput("mid_words_before", {16'd0, bus.words_loaded}, 32'd1);
        #2 rst = 1'b1;
        #1;
        checkOutput("mid_rst_we", {31'd0, bus.mem_we}, 32'd0);
        checkOutput("mid_rst_addr", bus.mem_addr, 32'h0);
        checkOutput("mid_rst_data", bus.mem_data, 32'h0);
        checkOutput("mid_rst_words", {16'd0, bus.words_loaded}, 32'd0);
        checkOutput("mid_rst_done", {31'd0, bus.done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        clearCapture();
        d = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1, 8'hB2, 8'hB3, 8'hB4};
        applyFrame(16'd2, d, 0);
        repeat (3) @(negedge clk);
        checkOutput("mid_nwrites", wrAddr.size(), 32'd2);
        checkWrite(0, 32'h0, 32'hA4A3_A2A1);
        checkWrite(1, 32'h4, 32'hB4B3_B2B1);

        // Eight words streamed with rx_valid high every cycle
        applyReset();
        d = {};
        for (int i = 0; i < 32; i++) d.push_back(8'(i + 8'h40));
        applyFrame(16'd8, d, 0);
        repeat (3) @(negedge clk);
        checkOutput("burst_nwrites", wrAddr.size(), 32'd8);
        for (int k = 0; k < 8; k++)
            checkWrite(k, 32'(4 * k),
                       {8'(4 * k + 3 + 8'h40), 8'(4 * k + 2 + 8'h40),
                        8'(4 * k + 1 + 8'h40), 8'(4 * k + 8'h40)});
        checkOutput("burst_words", {16'd0, bus.words_loaded}, 32'd8);
        checkOutput("burst_done", {31'd0, bus.done}, 32'd1);
        checkOutput("burst_err", errCount, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/uart_loader_ctrl.md
UART_LOADER_CTRL -- requirements
Module: uart_loader_ctrl

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, which is the byte address of the first loaded word.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 5_000_000, which is the maximum clock count allowed between bytes of one frame.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port rx_data, input, 8 bits: received UART byte.
REQ-006 SHALL have port rx_valid, input, 1 bit: one-cycle strobe that qualifies rx_data.
REQ-007 SHALL have port mem_we, output, 1 bit: instruction/data memory write strobe.
REQ-008 SHALL have port mem_addr, output, 32 bits: memory byte address.
REQ-009 SHALL have port mem_data, output, 32 bits: memory write word.
REQ-010 SHALL have port done, output, 1 bit: image fully loaded; sticky; drives CPU clock and reset release.
REQ-011 SHALL have port err, output, 1 bit: one-cycle pulse on frame abort.
REQ-012 SHALL have port words_loaded, output, 16 bits: count of words written in the current frame.

Function
REQ-013 Frame format SHALL be: LEN_HI, LEN_LO (N = word count, big-endian), then N words of 4 bytes each (little-endian), then an optional checksum byte (REQ-027).
REQ-014 FSM states SHALL be LEN_HI, LEN_LO, DATA, CHECK, DONE; the state after reset SHALL be LEN_HI.
REQ-015 LEN_HI SHALL go to LEN_LO, and LEN_LO SHALL go to DATA, each on rx_valid; if N==0, LEN_LO SHALL go directly to CHECK (checksum on) or DONE (checksum off).
REQ-016 In DATA, bytes SHALL be assembled byte0 into [7:0] through byte3 into [31:24].
REQ-017 On the cycle after the 4th byte of a word, mem_we SHALL be 1 for exactly one cycle, with mem_addr = BASE_ADDR + 4*index and mem_data = the assembled word.
REQ-018 words_loaded SHALL increment in the same cycle as mem_we; after the Nth word, the FSM SHALL go to CHECK or DONE.
REQ-019 mem_addr arithmetic SHALL be 32-bit, wrapping modulo 2^32 with no error.
REQ-020 DONE SHALL assert done=1 one cycle after entry; done SHALL hold until rst, and all rx_valid in DONE SHALL be ignored.
REQ-021 Timeout: in any state other than LEN_HI and DONE, if TIMEOUT_CYC cycles elapse without rx_valid, the block SHALL pulse err, clear the assembler and words_loaded, and return to LEN_HI.
REQ-022 The gap counter SHALL restart on every accepted byte.
REQ-023 rx_valid arriving in the same cycle as timeout expiry SHALL take priority: the byte is accepted and no err is raised.
REQ-024 While mem_we is high, a new rx_valid SHALL still be accepted; assembly is single-cycle per byte, with no back-pressure.
REQ-025 An err-caused restart SHALL NOT erase memory; the next frame overwrites from BASE_ADDR.

Reset
REQ-026 On rst, asynchronously: state=LEN_HI, mem_we=0, mem_addr=BASE_ADDR, mem_data=0, done=0, err=0, words_loaded=0, gap counter=0, checksum accumulator=0; a reset mid-frame SHALL discard the partial frame.

Configuration
REQ-027 With LOADER_CHECKSUM_EN defined: the checksum byte follows the data. In CHECK, when the byte equals the XOR of all data bytes, the FSM SHALL go to DONE; otherwise it SHALL pulse err and go to LEN_HI.
REQ-028 Without LOADER_CHECKSUM_EN: the CHECK state, the accumulator and the checksum byte SHALL be absent, and the last word SHALL lead directly to DONE.

Structure
REQ-029 Package loader_pkg SHALL hold the state enum, LOADER_LEN_WID=16, LOADER_BYTE_WID=8 and the default TIMEOUT_CYC.
REQ-030 The gap counter SHALL be sub-module loader_timeout (inputs clk, rst, restart, enable; output expired).
REQ-031 The byte assembler and FSM SHALL stay in uart_loader_ctrl.

Verification
REQ-032 Frame 00 02 | 78 56 34 12 | EF BE AD DE (checksum off) SHALL produce writes (0x0,0x12345678) and (0x4,0xDEADBEEF); done=1 one cycle after DONE entry; words_loaded=2.
REQ-033 Frame 00 00 SHALL produce done with zero mem_we; extra bytes afterwards SHALL produce no writes.
REQ-034 With TIMEOUT_CYC=16, a 20-cycle gap after byte 2 of the first word SHALL produce one err pulse. A fresh 1-word frame 00 01 11 22 33 44 SHALL then write 0x44332211 at address 0x0.
REQ-035 With checksum on, 00 01 01 02 03 04 04 SHALL give done. The same frame with checksum 05 SHALL give err, no done, and state LEN_HI.
REQ-036 rst asserted after 5 of 8 data bytes SHALL clear all outputs immediately. A new full frame SHALL then load from BASE_ADDR.
REQ-037 Back-to-back rx_valid every cycle for an 8-word frame SHALL produce 8 mem_we pulses with consecutive addresses and no dropped byte.
